// File: rtl/button_event_arbiter.sv
// Button front end: per-button sync + tick-paced shift-register debounce, press-event latching,
// and round-robin arbitration of pending presses onto one valid/ready event channel.
module button_event_arbiter #(
    parameter int unsigned N_BTN    = 4,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned TICK_DIV = 1000,
    parameter int unsigned IDX_W    = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_BTN-1:0] btn_raw_i,
    input  logic             evt_ready_i,
    input  logic             overrun_clr_i,
    output logic             evt_valid_o,
    output logic [IDX_W-1:0] evt_idx_o,
    output logic [N_BTN-1:0] btn_level_o,
    output logic             overrun_o
);

    typedef enum logic {StIdle, StOffer} state_e;

    state_e                         state_q, state_d;
    logic [15:0]                    cnt_q, cnt_d;
    logic                           tick;
    logic [N_BTN-1:0]               sync1_q, sync2_q;
    logic [N_BTN-1:0][DEPTH-1:0]    sh_q, sh_d;
    logic [N_BTN-1:0]               level_q, level_d, prev_q;
    logic [N_BTN-1:0]               pending_q, pending_d;
    logic [N_BTN-1:0]               rise, clr, ovr;
    logic [IDX_W-1:0]               evt_idx_q, evt_idx_d, rr_q, rr_d;
    logic                           overrun_q, overrun_d;
    logic                           accept;

    // First pending request at or after ptr, wrapping modulo N_BTN.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_BTN-1:0] req,
                                                 input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] pick;
        logic             found;
        int unsigned      j;
        pick  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N_BTN; k++) begin
            j = (32'(ptr) + k) % N_BTN;
            if (!found && req[j]) begin
                found = 1'b1;
                pick  = IDX_W'(j);
            end
        end
        return pick;
    endfunction

    always_comb begin
        tick  = (cnt_q == 16'(TICK_DIV - 1));
        cnt_d = tick ? '0 : cnt_q + 16'd1;
    end

    // Level follows the post-shift window; mixed windows hold the previous level.
    always_comb begin
        sh_d    = sh_q;
        level_d = level_q;
        if (tick) begin
            for (int unsigned i = 0; i < N_BTN; i++) begin
                sh_d[i] = {sh_q[i][DEPTH-2:0], sync2_q[i]};
                if (&sh_d[i]) begin
                    level_d[i] = 1'b1;
                end else if (~|sh_d[i]) begin
                    level_d[i] = 1'b0;
                end
            end
        end
    end

    // A rise coinciding with acceptance of the same button re-arms it instead of overrunning.
    always_comb begin
        accept    = (state_q == StOffer) && evt_ready_i;
        rise      = level_q & ~prev_q;
        clr       = accept ? (N_BTN'(1) << evt_idx_q) : '0;
        ovr       = rise & pending_q & ~clr;
        pending_d = (pending_q & ~clr) | rise;
        if (|ovr) begin
            overrun_d = 1'b1;
        end else if (overrun_clr_i) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        evt_idx_d = evt_idx_q;
        rr_d      = rr_q;
        unique case (state_q)
            StIdle: begin
                if (|pending_q) begin
                    evt_idx_d = rr_pick(pending_q, rr_q);
                    state_d   = StOffer;
                end
            end
            StOffer: begin
                if (evt_ready_i) begin
                    rr_d    = (evt_idx_q == IDX_W'(N_BTN - 1)) ? '0 : evt_idx_q + IDX_W'(1);
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            sh_q      <= '0;
            level_q   <= '0;
            prev_q    <= '0;
            pending_q <= '0;
            evt_idx_q <= '0;
            rr_q      <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sync1_q   <= btn_raw_i;
            sync2_q   <= sync1_q;
            sh_q      <= sh_d;
            level_q   <= level_d;
            prev_q    <= level_q;
            pending_q <= pending_d;
            evt_idx_q <= evt_idx_d;
            rr_q      <= rr_d;
            overrun_q <= overrun_d;
        end
    end

    assign evt_valid_o = (state_q == StOffer);
    assign evt_idx_o   = evt_idx_q;
    assign btn_level_o = level_q;
    assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed + randomized bench for button_event_arbiter, checked every cycle against a
// queue-based model of the sampling window, pending set and round-robin offer channel.
module tb_button_event_arbiter;

    localparam int unsigned N        = 4;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned IDX_W    = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     btn_raw = '0;
    logic             evt_ready = 1'b0;
    logic             overrun_clr = 1'b0;
    logic             evt_valid;
    logic [IDX_W-1:0] evt_idx;
    logic [N-1:0]     btn_level;
    logic             overrun;

    int vectors = 0;
    int miscompares = 0;

    button_event_arbiter #(
        .N_BTN(N), .DEPTH(DEPTH), .TICK_DIV(TICK_DIV), .IDX_W(IDX_W)
    ) dut (
        .clk_i(clk), .rst_i(rst), .btn_raw_i(btn_raw), .evt_ready_i(evt_ready),
        .overrun_clr_i(overrun_clr), .evt_valid_o(evt_valid), .evt_idx_o(evt_idx),
        .btn_level_o(btn_level), .overrun_o(overrun)
    );

    always #5 clk = ~clk;

    // Reference model state
    int           m_edges;
    logic [N-1:0] m_syncq [$];
    bit           m_samp [N][$];
    bit [N-1:0]   m_level, m_prev, m_pend;
    bit           m_offer, m_ovr;
    int           m_idx, m_rr;

    function automatic void model_reset();
        m_edges = 0;
        m_syncq = {};
        m_syncq.push_back('0);
        m_syncq.push_back('0);
        for (int i = 0; i < N; i++) begin
            m_samp[i] = {};
            for (int d = 0; d < DEPTH; d++) m_samp[i].push_back(1'b0);
        end
        m_level = '0; m_prev = '0; m_pend = '0;
        m_offer = 1'b0; m_ovr = 1'b0; m_idx = 0; m_rr = 0;
    endfunction

    function automatic void model_edge();
        logic [N-1:0] s;
        bit [N-1:0]   lvl_new, rise, pend_new;
        bit           tick, ovr_ev;
        int           ones;
        tick = (m_edges % TICK_DIV) == (TICK_DIV - 1);
        m_edges++;
        s = m_syncq.pop_front();
        m_syncq.push_back(btn_raw);
        lvl_new = m_level;
        if (tick) begin
            for (int i = 0; i < N; i++) begin
                void'(m_samp[i].pop_front());
                m_samp[i].push_back(s[i]);
                ones = 0;
                foreach (m_samp[i][d]) ones += int'(m_samp[i][d]);
                if (ones == DEPTH) lvl_new[i] = 1'b1;
                else if (ones == 0) lvl_new[i] = 1'b0;
            end
        end
        rise     = m_level & ~m_prev;
        pend_new = m_pend;
        ovr_ev   = 1'b0;
        if (m_offer && evt_ready) pend_new[m_idx] = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (rise[i]) begin
                if (pend_new[i]) ovr_ev = 1'b1;
                pend_new[i] = 1'b1;
            end
        end
        if (m_offer) begin
            if (evt_ready) begin
                m_offer = 1'b0;
                m_rr    = (m_idx + 1) % N;
            end
        end else if (m_pend != '0) begin
            for (int k = N - 1; k >= 0; k--) begin
                if (m_pend[(m_rr + k) % N]) m_idx = (m_rr + k) % N;
            end
            m_offer = 1'b1;
        end
        if (ovr_ev) m_ovr = 1'b1;
        else if (overrun_clr) m_ovr = 1'b0;
        m_prev  = m_level;
        m_level = lvl_new;
        m_pend  = pend_new;
    endfunction

    task automatic check();
        vectors++;
        assert (evt_valid === m_offer) else begin
            miscompares++;
            $error("FAIL evt_valid t=%0t got %b want %b", $time, evt_valid, m_offer);
        end
        assert (evt_idx === IDX_W'(m_idx)) else begin
            miscompares++;
            $error("FAIL evt_idx t=%0t got %0d want %0d", $time, evt_idx, m_idx);
        end
        assert (btn_level === m_level) else begin
            miscompares++;
            $error("FAIL btn_level t=%0t got %b want %b", $time, btn_level, m_level);
        end
        assert (overrun === m_ovr) else begin
            miscompares++;
            $error("FAIL overrun t=%0t got %b want %b", $time, overrun, m_ovr);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        #1;
        check();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic mid_reset(input logic [N-1:0] raw);
        btn_raw = raw;
        rst = 1'b1;
        model_reset();
        #1;
        check();
        run(2);
        rst = 1'b0;
    endtask

    initial begin
        bit hit;
        model_reset();
        run(3);
        rst = 1'b0;

        // Build up state, then reset asynchronously with all buttons held.
        btn_raw = 4'b1111;
        run(40);
        mid_reset(4'b1111);
        run(30);
        btn_raw = '0;
        evt_ready = 1'b1;
        run(60);

        // Single press with immediate acceptance.
        btn_raw = 4'b0010;
        run(50);
        btn_raw = '0;
        run(30);

        // Bounce on button 0 every tick, then a clean hold.
        for (int t = 0; t < 12; t++) begin
            btn_raw[0] = ~btn_raw[0];
            run(TICK_DIV);
        end
        btn_raw = 4'b0001;
        run(40);
        btn_raw = '0;
        run(30);

        // Round robin: simultaneous presses, then a wrapped pair.
        btn_raw = 4'b1101;
        run(40);
        btn_raw = '0;
        run(30);
        btn_raw = 4'b1001;
        run(40);
        btn_raw = '0;
        run(30);

        // Backpressure then overrun on re-press.
        evt_ready = 1'b0;
        btn_raw = 4'b0100;
        run(80);
        btn_raw = '0;
        run(30);
        btn_raw = 4'b0100;
        run(30);
        evt_ready = 1'b1;
        run(10);
        overrun_clr = 1'b1;
        run(1);
        overrun_clr = 1'b0;
        btn_raw = '0;
        run(30);

        // Accept-collision: acceptance lands on the same cycle the new rise is consumed.
        evt_ready = 1'b0;
        btn_raw = 4'b0010;
        run(40);
        btn_raw = '0;
        run(30);
        btn_raw = 4'b0010;
        hit = 1'b0;
        for (int c = 0; c < 80 && !hit; c++) begin
            if (m_level[1] && !m_prev[1]) begin
                evt_ready = 1'b1;
                hit = 1'b1;
            end
            step();
            evt_ready = 1'b0;
        end
        vectors++;
        assert (hit === 1'b1) else begin
            miscompares++;
            $error("FAIL collision_window got %b want 1", hit);
        end
        run(3);
        vectors++;
        assert ({evt_valid, evt_idx, overrun} === {1'b1, 2'd1, 1'b0}) else begin
            miscompares++;
            $error("FAIL collision_reoffer got v=%b i=%0d o=%b want v=1 i=1 o=0",
                   evt_valid, evt_idx, overrun);
        end
        evt_ready = 1'b1;
        btn_raw = '0;
        run(30);

        // Randomized segments: stable patterns, chatter, random ready/clear, occasional reset.
        for (int seg = 0; seg < 120; seg++) begin
            int len, mode;
            len  = $urandom_range(1, 40);
            mode = $urandom_range(0, 2);
            if ($urandom_range(0, 39) == 0) mid_reset(N'($urandom));
            if (mode == 0) btn_raw = N'($urandom);
            for (int c = 0; c < len; c++) begin
                if (mode == 1) btn_raw = N'($urandom);
                evt_ready   = ($urandom_range(0, 9) < 7);
                overrun_clr = ($urandom_range(0, 19) == 0);
                step();
            end
        end
        overrun_clr = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
